// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin APB master: arbitrates, runs SETUP/ACCESS, returns a done pulse.
// Optional ACCESS timeout is compiled in when APB_ARB_TIMEOUT_EN is defined.
module apb_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       req0,
  input  logic       req1,
  input  logic [8:0] addr0,
  input  logic [8:0] addr1,
  input  logic       wr0,
  input  logic       wr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata,
  output logic       err,
  output logic [8:0] paddr,
  output logic [7:0] pwdata,
  output logic       pwrite,
  output logic       penable,
  output logic       psel1,
  output logic       psel2,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   gnt, last_gnt;
  logic   elig0, elig1, win;
  logic   grant_now, complete, timed_out;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_req_arbiter: TIMEOUT_CYCLES must be in 2..255");
  end

  // A requester whose done pulse is on the bus this cycle is not eligible.
  always_comb begin
    elig0     = req0 & ~done0;
    elig1     = req1 & ~done1;
    win       = (elig0 & elig1) ? ~last_gnt : elig1;
    grant_now = 1'b0;
    complete  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          grant_now = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (pready | timed_out) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset)                          wait_cnt <= '0;
    else if (state == SETUP)             wait_cnt <= '0;
    else if (state == ACCESS && !pready) wait_cnt <= wait_cnt + 8'd1;
  end

  // pready on the terminal-count cycle takes precedence over the timeout.
  assign timed_out = (state == ACCESS) && !pready && (wait_cnt == LAST_WAIT);
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      paddr    <= '0;
      pwdata   <= '0;
      pwrite   <= 1'b0;
      rdata    <= '0;
      err      <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
    end else begin
      state <= state_nxt;
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (grant_now) begin
        gnt      <= win;
        last_gnt <= win;
        paddr    <= win ? addr1  : addr0;
        pwdata   <= win ? wdata1 : wdata0;
        pwrite   <= win ? wr1    : wr0;
      end
      if (complete) begin
        done0 <= ~gnt;
        done1 <= gnt;
        err   <= pready ? pslverr : 1'b1;
        if (!pwrite) rdata <= pready ? prdata : '0;
      end
    end
  end

  assign psel1   = (state != IDLE) & ~paddr[8];
  assign psel2   = (state != IDLE) &  paddr[8];
  assign penable = (state == ACCESS);

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: stimulus pushes expected SETUP/done records, a monitor pops and compares.
module tb_apb_req_arbiter;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [8:0] addr0 = '0, addr1 = '0;
  logic       wr0 = 1'b0, wr1 = 1'b0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       done0, done1, err, pwrite, penable, psel1, psel2;
  logic [7:0] rdata, pwdata;
  logic [8:0] paddr;
  logic [7:0] prdata = '0;
  logic       pready = 1'b0, pslverr = 1'b0;

  apb_req_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .preset(preset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wr0(wr0), .wr1(wr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .err(err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .penable(penable),
    .psel1(psel1), .psel2(psel2),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       s1;
    logic       s2;
    logic [8:0] a;
    logic [7:0] wd;
    logic       w;
  } ph_t;
  typedef struct {
    int         cyc;
    logic       who;
    logic [7:0] rd;
    logic       e;
  } dn_t;

  ph_t sq[$];
  dn_t dq[$];
  ph_t cur;
  dn_t dexp;
  bit  first_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model: pready after wait_cfg ACCESS cycles, data derived from the address.
  int         wait_cfg = 0, acc_n = 0;
  bit         hang = 1'b0, err_cfg = 1'b0;
  logic [7:0] rd_base = '0;
  always @(negedge pclk) begin
    if (penable) begin
      pready  = !hang && (acc_n >= wait_cfg);
      prdata  = rd_base ^ paddr[7:0];
      pslverr = err_cfg;
      acc_n++;
    end else begin
      pready  = 1'b0;
      prdata  = '0;
      pslverr = 1'b0;
      acc_n   = 0;
    end
  end

  always @(negedge pclk) begin
    if (!preset) begin
      if (psel1 | psel2) chk("psel_onehot", psel1 & psel2, 0);
      if ((psel1 | psel2) && !penable) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_setup: paddr %0h with no expected transfer (cycle %0d)", paddr, cyc);
        end else begin
          cur = sq.pop_front();
          chk("setup_cycle", cyc, cur.cyc);
          chk("setup_psel1", psel1, cur.s1);
          chk("setup_psel2", psel2, cur.s2);
          chk("setup_paddr", paddr, cur.a);
          chk("setup_pwdata", pwdata, cur.wd);
          chk("setup_pwrite", pwrite, cur.w);
          first_acc = 1'b1;
        end
      end
      if (penable) begin
        if (first_acc) chk("access_cycle", cyc, cur.cyc + 1);
        first_acc = 1'b0;
        chk("acc_psel1", psel1, cur.s1);
        chk("acc_psel2", psel2, cur.s2);
        chk("acc_paddr", paddr, cur.a);
        chk("acc_pwdata", pwdata, cur.wd);
        chk("acc_pwrite", pwrite, cur.w);
      end
      if (done0 | done1) begin
        chk("done_onehot", done0 & done1, 0);
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done0=%0b done1=%0b with none expected (cycle %0d)", done0, done1, cyc);
        end else begin
          dexp = dq.pop_front();
          chk("done_who", done1, dexp.who);
          chk("done_cycle", cyc, dexp.cyc);
          chk("done_rdata", rdata, dexp.rd);
          chk("done_err", err, dexp.e);
        end
      end
    end
  end

  task automatic expect_xfer(input bit who, input logic [8:0] a, input bit w, input logic [7:0] wd,
                             input int s_cyc, input int d_cyc, input logic [7:0] rd, input bit e,
                             input bit with_done);
    sq.push_back('{s_cyc, !a[8], a[8], a, wd, w});
    if (with_done) dq.push_back('{d_cyc, who, rd, e});
  endtask

  task automatic drive(input bit who, input logic [8:0] a, input bit w, input logic [7:0] wd);
    if (who) begin req1 = 1'b1; addr1 = a; wr1 = w; wdata1 = wd; end
    else     begin req0 = 1'b1; addr0 = a; wr0 = w; wdata0 = wd; end
  endtask

  task automatic wait_done(input bit who, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge pclk);
      if (who ? done1 : done0) seen = 1'b1;
    end
    if (who) req1 = 1'b0; else req0 = 1'b0;
    chk("done_seen", seen, 1);
  endtask

  task automatic next_cycle();
    @(posedge pclk);
    #1;
  endtask

  int         t, n;
  bit         seen;
  logic [8:0] a;

  initial begin
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_psel1", psel1, 0);
    chk("rst_psel2", psel2, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    preset = 1'b0;
    next_cycle();

    // Single read from slave 1, zero wait states.
    rd_base = 8'hA0; wait_cfg = 0;
    t = cyc;
    drive(0, 9'h005, 0, 8'h00);
    expect_xfer(0, 9'h005, 0, 8'h00, t + 1, t + 3, 8'hA5, 0, 1);
    wait_done(0, 20);
    next_cycle();

    // Write to slave 2 with two wait states; rdata must keep the last read.
    wait_cfg = 2;
    t = cyc;
    drive(1, 9'h10F, 1, 8'h3C);
    expect_xfer(1, 9'h10F, 1, 8'h3C, t + 1, t + 5, 8'hA5, 0, 1);
    wait_done(1, 20);
    next_cycle();

    // Slave error on a read, then a clean write clears err.
    wait_cfg = 0; err_cfg = 1'b1; rd_base = 8'h11;
    t = cyc;
    drive(0, 9'h033, 0, 8'hEE);
    expect_xfer(0, 9'h033, 0, 8'hEE, t + 1, t + 3, 8'h22, 1, 1);
    wait_done(0, 20);
    next_cycle();
    err_cfg = 1'b0;
    t = cyc;
    drive(1, 9'h1AA, 1, 8'h77);
    expect_xfer(1, 9'h1AA, 1, 8'h77, t + 1, t + 3, 8'h22, 0, 1);
    wait_done(1, 20);
    next_cycle();

    // Both requesters held high right after reset: 0,1,0,1 with SETUPs 3 cycles apart.
    preset = 1'b1;
    next_cycle();
    preset = 1'b0;
    next_cycle();
    rd_base = 8'hC3;
    t = cyc;
    drive(0, 9'h020, 0, 8'h01);
    drive(1, 9'h140, 0, 8'h02);
    for (int k = 0; k < 4; k++) begin
      a = (k % 2 == 1) ? 9'h140 : 9'h020;
      expect_xfer(k % 2 == 1, a, 0, (k % 2 == 1) ? 8'h02 : 8'h01,
                  t + 1 + 3 * k, t + 3 + 3 * k, 8'hC3 ^ a[7:0], 0, 1);
    end
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge pclk);
      if (done0 | done1) n++;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_done_count", n, 4);
    next_cycle();

    // Reset during ACCESS abandons the transfer without a done pulse.
    hang = 1'b1;
    t = cyc;
    drive(0, 9'h0F0, 0, 8'h55);
    expect_xfer(0, 9'h0F0, 0, 8'h55, t + 1, 0, 8'h00, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge pclk);
      if (penable) seen = 1'b1;
    end
    chk("mid_reached_access", seen, 1);
    preset = 1'b1;
    #1;
    chk("mid_psel1", psel1, 0);
    chk("mid_psel2", psel2, 0);
    chk("mid_penable", penable, 0);
    chk("mid_paddr", paddr, 0);
    chk("mid_done0", done0, 0);
    chk("mid_done1", done1, 0);
    req0 = 1'b0; hang = 1'b0;
    next_cycle();
    preset = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge pclk);
      if (done0 | done1) n++;
    end
    chk("mid_no_done", n, 0);
    next_cycle();

    // Slave never answers.
    hang = 1'b1;
    t = cyc;
    drive(0, 9'h077, 0, 8'h00);
`ifdef APB_ARB_TIMEOUT_EN
    expect_xfer(0, 9'h077, 0, 8'h00, t + 1, t + 6, 8'h00, 1, 1);
    wait_done(0, 30);
`else
    expect_xfer(0, 9'h077, 0, 8'h00, t + 1, 0, 8'h00, 0, 0);
    repeat (102) @(negedge pclk);
    chk("hang_penable", penable, 1);
    chk("hang_psel1", psel1, 1);
    chk("hang_done0", done0, 0);
    req0 = 1'b0;
    preset = 1'b1;
    next_cycle();
    preset = 1'b0;
`endif
    hang = 1'b0;
    repeat (3) next_cycle();
    chk("scoreboard_drained", sq.size() + dq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
